vga_overlay_mixer: RTL

Parametrised successor to the eye-tracker VGA output stage. Takes the per-pixel line-memory bits already selected by H address, the video timing strobes and the tracked point, and produces registered RGB plus delay-matched syncs. Adds multi-plane greyscale, a false-colour overlay mode, a crosshair cursor of configurable arm length and colour with frame-rate blinking, a configurable border, and per-frame shadowing of all controls. Sits between the line-buffer read side and the VGA/DVI encoder.

---
 rtl/vga_overlay_mixer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vga_overlay_mixer.sv
// rtl/vga_overlay_mixer.sv - two-stage VGA pixel mixer with frame-shadowed controls
// Greyscale/binary/overlay colouring, blinking crosshair cursor and border, syncs delay-matched.
module vga_overlay_mixer #(
  parameter int ADDR_WIDTH = 11,
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int PIXEL_WIDTH = 8,
  parameter int NPLANES = 6,
  parameter logic [PIXEL_WIDTH-1:0] BIN_LEVEL = 8'hC0,
  parameter int CURSOR_LEN = 1,
  parameter logic [3*PIXEL_WIDTH-1:0] CURSOR_RGB = 24'hFF0000,
  parameter logic [3*PIXEL_WIDTH-1:0] BORDER_RGB = 24'hFFFFFF,
  parameter int BLINK_FRAMES = 15
) (
  input  logic                   VCLK,
  input  logic                   RST,
  input  logic                   iVSYNC,
  input  logic                   iHSYNC,
  input  logic                   iDE,
  input  logic [ADDR_WIDTH-1:0]  iH_ADDR,
  input  logic [ADDR_WIDTH-1:0]  iV_ADDR,
  input  logic [NPLANES-1:0]     iPIX,
  input  logic [1:0]             iMODE,
  input  logic                   iCURSOR_EN,
  input  logic                   iBLINK_EN,
  input  logic                   iBORDER_EN,
  input  logic [ADDR_WIDTH-1:0]  iPOINT_X,
  input  logic [ADDR_WIDTH-1:0]  iPOINT_Y,
  output logic                   oVGA_HSYNC,
  output logic                   oVGA_VSYNC,
  output logic                   oVGA_DE,
  output logic [PIXEL_WIDTH-1:0] oVGA_R,
  output logic [PIXEL_WIDTH-1:0] oVGA_G,
  output logic [PIXEL_WIDTH-1:0] oVGA_B,
  output logic                   oFRAME_START
);

  localparam int DW  = ADDR_WIDTH + 1;
  localparam int PW3 = 3 * PIXEL_WIDTH;
  localparam int CW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic signed [DW-1:0] ARM = DW'(CURSOR_LEN);
  localparam logic [ADDR_WIDTH-1:0] H_LAST = ADDR_WIDTH'(HACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] V_LAST = ADDR_WIDTH'(VACTIVE - 1);
  localparam logic [1:0] MODE_BIN = 2'd0;
  localparam logic [1:0] MODE_OVL = 2'd2;
  localparam logic [PIXEL_WIDTH-1:0] ZERO_CH = '0;

  logic                  vsync_prev;
  logic                  frame_start;
  logic [1:0]            sh_mode;
  logic                  sh_cursor_en;
  logic                  sh_blink_en;
  logic                  sh_border_en;
  logic [ADDR_WIDTH-1:0] sh_px;
  logic [ADDR_WIDTH-1:0] sh_py;
  logic [CW-1:0]         blink_cnt;
  logic                  blink_phase;

  assign frame_start = iVSYNC & ~vsync_prev;

  // While in reset vsync_prev follows the input, so a high vsync at release is not a frame start.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      vsync_prev   <= iVSYNC;
      sh_mode      <= 2'd0;
      sh_cursor_en <= 1'b0;
      sh_blink_en  <= 1'b0;
      sh_border_en <= 1'b0;
      sh_px        <= '0;
      sh_py        <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b1;
    end else begin
      vsync_prev <= iVSYNC;
      if (frame_start) begin
        sh_mode      <= iMODE;
        sh_cursor_en <= iCURSOR_EN;
        sh_blink_en  <= iBLINK_EN;
        sh_border_en <= iBORDER_EN;
        sh_px        <= iPOINT_X;
        sh_py        <= iPOINT_Y;
        if (blink_cnt == CNT_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  logic signed [DW-1:0] dx;
  logic signed [DW-1:0] dy;
  logic signed [DW-1:0] dx_abs;
  logic signed [DW-1:0] dy_abs;
  logic                 cursor_vis;
  logic                 cursor_hit;
  logic                 border_hit;

  // One extra bit keeps the differences exact, so arms clip at the screen edge instead of wrapping.
  assign dx = $signed({1'b0, iH_ADDR}) - $signed({1'b0, sh_px});
  assign dy = $signed({1'b0, iV_ADDR}) - $signed({1'b0, sh_py});
  assign dx_abs = dx[DW-1] ? -dx : dx;
  assign dy_abs = dy[DW-1] ? -dy : dy;

  assign cursor_vis = sh_cursor_en & (blink_phase | ~sh_blink_en);
  assign cursor_hit = cursor_vis &
                      (((iV_ADDR == sh_py) && (dx_abs <= ARM)) ||
                       ((iH_ADDR == sh_px) && (dy_abs <= ARM)));
  assign border_hit = sh_border_en &
                      ((iH_ADDR == '0) || (iH_ADDR == H_LAST) ||
                       (iV_ADDR == '0) || (iV_ADDR == V_LAST));

  logic               s1_de;
  logic               s1_hs;
  logic               s1_vs;
  logic               s1_fs;
  logic               s1_cursor;
  logic               s1_border;
  logic [NPLANES-1:0] s1_pix;
  logic [1:0]         s1_mode;

  always_ff @(posedge VCLK) begin
    if (RST) begin
      s1_de     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_fs     <= 1'b0;
      s1_cursor <= 1'b0;
      s1_border <= 1'b0;
      s1_pix    <= '0;
      s1_mode   <= 2'd0;
    end else begin
      s1_de     <= iDE;
      s1_hs     <= iHSYNC;
      s1_vs     <= iVSYNC;
      s1_fs     <= frame_start;
      s1_cursor <= cursor_hit;
      s1_border <= border_hit;
      s1_pix    <= iPIX;
      s1_mode   <= sh_mode;
    end
  end

  logic [PIXEL_WIDTH-1:0] grey;
  logic [PIXEL_WIDTH-1:0] bin_px;
  logic [PW3-1:0]         mode_rgb;
  logic [PW3-1:0]         rgb_next;

  // Plane 1 lands on the channel MSB, higher planes on successively lower bits.
  always_comb begin
    grey = '0;
    for (int k = 1; k < NPLANES; k++) begin
      grey[PIXEL_WIDTH-k] = s1_pix[k];
    end
    bin_px = s1_pix[0] ? BIN_LEVEL : ZERO_CH;
    case (s1_mode)
      MODE_BIN: mode_rgb = {bin_px, bin_px, bin_px};
      MODE_OVL: mode_rgb = s1_pix[0] ? {ZERO_CH, BIN_LEVEL, ZERO_CH} : {grey, grey, grey};
      default:  mode_rgb = {grey, grey, grey};
    endcase
    if (!s1_de) begin
      rgb_next = '0;
    end else if (s1_cursor) begin
      rgb_next = CURSOR_RGB;
    end else if (s1_border) begin
      rgb_next = BORDER_RGB;
    end else begin
      rgb_next = mode_rgb;
    end
  end

  always_ff @(posedge VCLK) begin
    if (RST) begin
      oVGA_HSYNC   <= 1'b0;
      oVGA_VSYNC   <= 1'b0;
      oVGA_DE      <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oFRAME_START <= 1'b0;
    end else begin
      oVGA_HSYNC   <= s1_hs;
      oVGA_VSYNC   <= s1_vs;
      oVGA_DE      <= s1_de;
      oVGA_R       <= rgb_next[PW3-1 -: PIXEL_WIDTH];
      oVGA_G       <= rgb_next[2*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
      oVGA_B       <= rgb_next[PIXEL_WIDTH-1:0];
      oFRAME_START <= s1_fs;
    end
  end

endmodule
